// File: rtl/ramio_pkg.sv
// Shared ramio encodings and arbiter state type, used by core, ramio and the arbiter.
package ramio_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_B    = 3'b001;
    localparam logic [2:0] RD_H    = 3'b010;
    localparam logic [2:0] RD_W    = 3'b011;
    localparam logic [2:0] RD_SEXT = 3'b100;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_B    = 2'b01;
    localparam logic [1:0] WR_H    = 2'b10;
    localparam logic [1:0] WR_W    = 2'b11;

    typedef enum logic [1:0] {Idle, Grant0, Grant1} arb_state_e;

    typedef struct packed {
        logic        enable;
        logic [2:0]  read_type;
        logic [1:0]  write_type;
        logic [31:0] address;
        logic [31:0] data_in;
    } ramio_req_t;

    function automatic arb_state_e grant_of(input logic idx);
        return idx ? Grant1 : Grant0;
    endfunction

endpackage

// File: rtl/ramio_arbiter_rr_pick.sv
// Two-way requester pick: single request wins outright, ties resolved by
// alternation against 'last' or by a fixed winner.
module rr_pick #(
    parameter int RoundRobin  = 1,
    parameter int FixedWinner = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       idx
);

    localparam logic FIXED = 1'(FixedWinner);

    always_comb begin
        valid = |req;
        idx   = req[1];
        if (&req)
            idx = (RoundRobin != 0) ? ~last : FIXED;
    end

endmodule

// File: rtl/ramio_arbiter.sv
// Two-requester ramio port arbiter (0 = core, 1 = loader). Grants whole
// transactions and muxes the owner onto ramio combinationally.
module ramio_arbiter
    import ramio_pkg::*;
#(
    parameter int RoundRobin     = 1,
    parameter int FixedWinner    = 0,
    parameter int MaxGrantCycles = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_enable,
    input  logic [1:0][2:0]       m_read_type,
    input  logic [1:0][1:0]       m_write_type,
    input  logic [1:0][31:0]      m_address,
    input  logic [1:0][31:0]      m_data_in,
    output logic [1:0][31:0]      m_data_out,
    output logic [1:0]            m_data_out_ready,
    output logic [1:0]            m_busy,
    output logic                  ramio_enable,
    output logic [2:0]            ramio_read_type,
    output logic [1:0]            ramio_write_type,
    output logic [31:0]           ramio_address,
    output logic [31:0]           ramio_data_in,
    input  logic [31:0]           ramio_data_out,
    input  logic                  ramio_data_out_ready,
    input  logic                  ramio_busy,
    output logic                  grant_timeout
);

    localparam logic [31:0] MAX_C = 32'(MaxGrantCycles);

    arb_state_e  state, state_nxt;
    logic        last, last_nxt;
    logic [31:0] hold_cnt, hold_nxt;
    logic        timeout_set;
    logic        owned, own, other;
    logic        pick_vld, pick_idx;
    ramio_req_t [1:0] req;
    ramio_req_t  dn;

    assign owned = (state != Idle);
    assign own   = (state == Grant1);
    assign other = ~own;

    rr_pick #(
        .RoundRobin  (RoundRobin),
        .FixedWinner (FixedWinner)
    ) u_pick (
        .req   (m_enable),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            Idle: if (pick_vld) state_nxt = grant_of(pick_idx);
            Grant0, Grant1: begin
                // Owner is done only once ramio has also drained its access.
                if (!m_enable[own] && !ramio_busy) begin
                    last_nxt  = own;
                    state_nxt = m_enable[other] ? grant_of(other) : Idle;
                end
            end
            default: state_nxt = Idle;
        endcase
    end

    always_comb begin
        hold_nxt = hold_cnt;
        if (state == Idle || state_nxt != state)
            hold_nxt = '0;
        else if (hold_cnt != MAX_C)
            hold_nxt = hold_cnt + 32'd1;
        timeout_set = owned && (state_nxt == state) && (hold_nxt == MAX_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= Idle;
            last          <= 1'b1;
            hold_cnt      <= '0;
            grant_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            if (timeout_set)
                grant_timeout <= 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_port
        logic is_owner;
        assign req[g] = '{enable:     m_enable[g],
                          read_type:  m_read_type[g],
                          write_type: m_write_type[g],
                          address:    m_address[g],
                          data_in:    m_data_in[g]};
        assign is_owner              = owned && (own == 1'(g));
        assign m_data_out[g]         = is_owner ? ramio_data_out : '0;
        assign m_data_out_ready[g]   = is_owner & ramio_data_out_ready;
        assign m_busy[g]             = is_owner ? ramio_busy : m_enable[g];
    end

    assign dn               = owned ? req[own] : '0;
    assign ramio_enable     = dn.enable;
    assign ramio_read_type  = dn.read_type;
    assign ramio_write_type = dn.write_type;
    assign ramio_address    = dn.address;
    assign ramio_data_in    = dn.data_in;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Bench for ramio_arbiter: acts as both requesters and as ramio, with a read-data scoreboard.
module tb_ramio_arbiter;
    import ramio_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       m_enable;
    logic [1:0][2:0]  m_read_type;
    logic [1:0][1:0]  m_write_type;
    logic [1:0][31:0] m_address, m_data_in, m_data_out;
    logic [1:0]       m_data_out_ready, m_busy;
    logic             ramio_enable;
    logic [2:0]       ramio_read_type;
    logic [1:0]       ramio_write_type;
    logic [31:0]      ramio_address, ramio_data_in, ramio_data_out;
    logic             ramio_data_out_ready, ramio_busy, grant_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct { logic idx; logic [31:0] data; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [1:0] en; logic busy; logic rdy;
        logic [1:0] own; logic ren; logic [1:0] mbusy;
    } row_t;
    row_t tbl[15];

    localparam logic [31:0] RD = 32'h5555_AAAA;

    ramio_arbiter dut (
        .clk(clk), .rst(rst),
        .m_enable(m_enable), .m_read_type(m_read_type), .m_write_type(m_write_type),
        .m_address(m_address), .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_data_out_ready(m_data_out_ready), .m_busy(m_busy),
        .ramio_enable(ramio_enable), .ramio_read_type(ramio_read_type),
        .ramio_write_type(ramio_write_type), .ramio_address(ramio_address),
        .ramio_data_in(ramio_data_in), .ramio_data_out(ramio_data_out),
        .ramio_data_out_ready(ramio_data_out_ready), .ramio_busy(ramio_busy),
        .grant_timeout(grant_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic req(input int i, input logic en, input logic [2:0] rt, input logic [1:0] wt,
                       input logic [31:0] a, input logic [31:0] d);
        m_enable[i]     = en;
        m_read_type[i]  = rt;
        m_write_type[i] = wt;
        m_address[i]    = a;
        m_data_in[i]    = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Every ready seen by a requester must match the next queued read.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_data_out_ready[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected: got ready on %0d want none", i);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_idx", 32'(i), 32'(mon_e.idx));
                    chk("sb_data", m_data_out[i], mon_e.data);
                end
            end
        end
    end

    initial begin
        m_enable = '0; m_read_type = '0; m_write_type = '0; m_address = '0; m_data_in = '0;
        ramio_data_out = '0; ramio_data_out_ready = 1'b0; ramio_busy = 1'b0;
        tick();
        do_reset();
        settle();
        chk("rst_ren", 32'(ramio_enable), 32'd0);
        chk("rst_timeout", 32'(grant_timeout), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_addr", ramio_address, 32'd0);

        // Single requester read
        req(0, 1'b1, RD_W, WR_NONE, 32'h10, 32'h0);
        settle();
        chk("t1_busy_idle", 32'(m_busy[0]), 32'd1);
        chk("t1_ren_idle", 32'(ramio_enable), 32'd0);
        tick(); settle();
        chk("t1_ren", 32'(ramio_enable), 32'd1);
        chk("t1_addr", ramio_address, 32'h10);
        chk("t1_rtype", 32'(ramio_read_type), 32'(RD_W));
        ramio_busy = 1'b1;
        tick();
        ramio_busy = 1'b0; ramio_data_out = 32'hDEAD_BEEF; ramio_data_out_ready = 1'b1;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        settle();
        chk("t1_data", m_data_out[0], 32'hDEAD_BEEF);
        chk("t1_other_busy", 32'(m_busy[1]), 32'd0);
        chk("t1_other_data", m_data_out[1], 32'd0);
        tick();
        ramio_data_out_ready = 1'b0; ramio_data_out = '0; m_enable[0] = 1'b0;
        tick();

        // Contention / release / late-busy sequence
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b11};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 2'b10};
        tbl[3]  = '{2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 2'b11};
        tbl[4]  = '{2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 2'b11};
        tbl[5]  = '{2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 2'b11};
        tbl[6]  = '{2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 2'b10};
        tbl[7]  = '{2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00};
        tbl[8]  = '{2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[10] = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11};
        tbl[11] = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01};
        tbl[12] = '{2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01};
        tbl[13] = '{2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00};
        tbl[14] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        do_reset();
        req(0, 1'b0, RD_W, WR_NONE, 32'h100, 32'hA0);
        req(1, 1'b0, RD_NONE, WR_W, 32'h200, 32'hB0);
        ramio_data_out = RD;
        for (int k = 0; k < 15; k++) begin
            logic [31:0] ea, ed;
            logic [1:0]  ew;
            m_enable = tbl[k].en; ramio_busy = tbl[k].busy; ramio_data_out_ready = tbl[k].rdy;
            if (tbl[k].rdy && tbl[k].own != 2'b00) sb.push_back('{tbl[k].own[1], RD});
            ea = tbl[k].own[0] ? 32'h100 : (tbl[k].own[1] ? 32'h200 : 32'h0);
            ed = tbl[k].own[0] ? 32'hA0  : (tbl[k].own[1] ? 32'hB0  : 32'h0);
            ew = tbl[k].own[1] ? WR_W : WR_NONE;
            settle();
            chk($sformatf("v%0d_ren", k), 32'(ramio_enable), 32'(tbl[k].ren));
            chk($sformatf("v%0d_mbusy", k), 32'(m_busy), 32'(tbl[k].mbusy));
            chk($sformatf("v%0d_addr", k), ramio_address, ea);
            chk($sformatf("v%0d_din", k), ramio_data_in, ed);
            chk($sformatf("v%0d_wtype", k), 32'(ramio_write_type), 32'(ew));
            chk($sformatf("v%0d_rdy", k), 32'(m_data_out_ready), 32'(tbl[k].own & {2{tbl[k].rdy}}));
            chk($sformatf("v%0d_dout0", k), m_data_out[0], tbl[k].own[0] ? RD : 32'h0);
            chk($sformatf("v%0d_dout1", k), m_data_out[1], tbl[k].own[1] ? RD : 32'h0);
            chk($sformatf("v%0d_timeout", k), 32'(grant_timeout), 32'd0);
            tick();
        end
        ramio_data_out = '0; ramio_data_out_ready = 1'b0; ramio_busy = 1'b0;

        // Core store->fetch under one grant while loader waits
        do_reset();
        req(0, 1'b1, RD_NONE, WR_W, 32'h20, 32'hCAFE);
        req(1, 1'b1, RD_W, WR_NONE, 32'h300, 32'h0);
        tick();
        ramio_busy = 1'b1;
        settle();
        chk("t3_sw_addr", ramio_address, 32'h20);
        chk("t3_sw_wtype", 32'(ramio_write_type), 32'(WR_W));
        chk("t3_ld_busy", 32'(m_busy[1]), 32'd1);
        tick();
        ramio_busy = 1'b0;
        req(0, 1'b1, RD_W, WR_NONE, 32'h24, 32'h0);
        settle();
        chk("t3_lw_addr", ramio_address, 32'h24);
        chk("t3_lw_rtype", 32'(ramio_read_type), 32'(RD_W));
        tick();
        ramio_data_out = 32'h1234_5678; ramio_data_out_ready = 1'b1;
        sb.push_back('{1'b0, 32'h1234_5678});
        settle();
        chk("t3_ld_rdy", 32'(m_data_out_ready[1]), 32'd0);
        chk("t3_core_data", m_data_out[0], 32'h1234_5678);
        tick();
        ramio_data_out = '0; ramio_data_out_ready = 1'b0; m_enable[0] = 1'b0;
        settle();
        chk("t3_hold_addr", ramio_address, 32'h24);
        tick(); settle();
        chk("t3_switch_addr", ramio_address, 32'h300);
        chk("t3_switch_ren", 32'(ramio_enable), 32'd1);
        m_enable[1] = 1'b0;
        tick(); settle();
        chk("t3_idle_ren", 32'(ramio_enable), 32'd0);

        // Grant hold timeout
        req(1, 1'b1, RD_W, WR_NONE, 32'h400, 32'h0);
        tick();
        repeat (4095) tick();
        settle();
        chk("t5_before", 32'(grant_timeout), 32'd0);
        tick(); settle();
        chk("t5_at", 32'(grant_timeout), 32'd1);
        chk("t5_still_owner", ramio_address, 32'h400);
        m_enable[1] = 1'b0;
        tick(); tick(); settle();
        chk("t5_sticky", 32'(grant_timeout), 32'd1);
        chk("t5_idle_ren", 32'(ramio_enable), 32'd0);

        // Reset mid-write, then first tie
        req(0, 1'b1, RD_NONE, WR_W, 32'h40, 32'hFEED);
        tick(); settle();
        chk("t6_ren", 32'(ramio_enable), 32'd1);
        rst = 1'b1; ramio_busy = 1'b1;
        tick(); settle();
        chk("t6_rst_ren", 32'(ramio_enable), 32'd0);
        chk("t6_rst_timeout", 32'(grant_timeout), 32'd0);
        chk("t6_rst_busy0", 32'(m_busy[0]), 32'd1);
        rst = 1'b0; ramio_busy = 1'b0;
        req(1, 1'b1, RD_W, WR_NONE, 32'h500, 32'h0);
        tick(); settle();
        chk("t6_tie_addr", ramio_address, 32'h40);
        m_enable = '0;
        tick(); tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
